// File: rtl/cpu_dst_pipe_if.sv
// Bus between the decode/hazard-detector side and the destination-tag pipe.
// The pipe (cpu_dst_pipe) connects through the slave modport.
// The decode side (or a testbench) connects through the master modport.
// CSQ bit order is {CS, C, S, E, M}.
interface cpu_dst_pipe_if #(
  parameter int TAG_W = 3,
  parameter int CSQ_W = 5
);
  // Decode-side request and pipe control.
  logic [TAG_W-1:0] D_DST_I;
  logic             D_VALID_I;
  logic [CSQ_W-1:0] D_CSQ_I;
  logic             BUBBLE_DATA_I;
  logic             FLUSH_I;
  logic             MEM_WAIT_I;

  // Pipe response and per-stage hazard buses.
  logic             D_ACCEPT_O;
  logic [TAG_W-1:0] E_DST_O;
  logic [TAG_W-1:0] M_DST_O;
  logic [TAG_W-1:0] W_DST_O;
  logic             E_VALID_O;
  logic             M_VALID_O;
  logic             W_VALID_O;
  logic [CSQ_W-1:0] E_CSQ_O;
  logic [CSQ_W-1:0] M_CSQ_O;
  logic [CSQ_W-1:0] W_CSQ_O;
  logic             HAZARD_TIMEOUT_O;

  modport master (
    output D_DST_I, D_VALID_I, D_CSQ_I, BUBBLE_DATA_I, FLUSH_I, MEM_WAIT_I,
    input  D_ACCEPT_O,
    input  E_DST_O, M_DST_O, W_DST_O,
    input  E_VALID_O, M_VALID_O, W_VALID_O,
    input  E_CSQ_O, M_CSQ_O, W_CSQ_O,
    input  HAZARD_TIMEOUT_O
  );

  modport slave (
    input  D_DST_I, D_VALID_I, D_CSQ_I, BUBBLE_DATA_I, FLUSH_I, MEM_WAIT_I,
    output D_ACCEPT_O,
    output E_DST_O, M_DST_O, W_DST_O,
    output E_VALID_O, M_VALID_O, W_VALID_O,
    output E_CSQ_O, M_CSQ_O, W_CSQ_O,
    output HAZARD_TIMEOUT_O
  );
endinterface

// File: rtl/cpu_dst_pipe.sv
// Destination-tag pipe: the writer side of the data-hazard check.
// It carries each issued instruction's destination tag and write qualifiers
// through the E, M and W stages, and exposes them to the hazard detector.
// It inserts bubbles on request, kills E on flush, and freezes on memory wait.
// A sticky HAZARD_TIMEOUT_O flags a bubble streak longer than MAX_BUBBLE.
// Optional feature macro CPU_DST_PIPE_STAT_EN adds the saturating
// STAT_BUBBLE_CNT_O and STAT_FLUSH_CNT_O event counters.
module cpu_dst_pipe #(
  parameter int TAG_W      = 3,
  parameter int CSQ_W      = 5,
  parameter int MAX_BUBBLE = 3
) (
  input  logic CLK_I,
  input  logic RST_I,
  cpu_dst_pipe_if.slave pipe_if
`ifdef CPU_DST_PIPE_STAT_EN
  ,
  output logic [15:0] STAT_BUBBLE_CNT_O,
  output logic [15:0] STAT_FLUSH_CNT_O
`endif
);

  // The counter must be able to hold MAX_BUBBLE+1, the saturation point.
  localparam int CNT_W = $clog2(MAX_BUBBLE + 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BUBBLE + 1);

  // What the pipe does on the coming edge, in priority order.
  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_FLUSH   = 2'd2,
    ACT_HOLD    = 2'd3
  } act_e;

  act_e cycle_act;

  // Stage state and its next-state values.
  logic [TAG_W-1:0] e_dst_q, e_dst_d;
  logic [TAG_W-1:0] m_dst_q, m_dst_d;
  logic [TAG_W-1:0] w_dst_q, w_dst_d;
  logic             e_vld_q, e_vld_d;
  logic             m_vld_q, m_vld_d;
  logic             w_vld_q, w_vld_d;
  logic [CSQ_W-1:0] e_csq_q, e_csq_d;
  logic [CSQ_W-1:0] m_csq_q, m_csq_d;
  logic [CSQ_W-1:0] w_csq_q, w_csq_d;
  logic [CNT_W-1:0] bub_cnt_q, bub_cnt_d;
  logic             timeout_q, timeout_d;

  // Resolve the per-edge action: wait beats flush, flush beats bubble.
  always_comb begin
    cycle_act = ACT_ADVANCE;
    if (pipe_if.MEM_WAIT_I) begin
      cycle_act = ACT_HOLD;
    end else if (pipe_if.FLUSH_I) begin
      cycle_act = ACT_FLUSH;
    end else if (pipe_if.BUBBLE_DATA_I) begin
      cycle_act = ACT_BUBBLE;
    end else begin
      cycle_act = ACT_ADVANCE;
    end
  end

  // Decode leaves only on a plain advance; this is the sole combinational output.
  assign pipe_if.D_ACCEPT_O = (cycle_act == ACT_ADVANCE);

  // Next-state for the stage registers and the bubble-streak counter.
  always_comb begin
    e_dst_d   = e_dst_q;
    m_dst_d   = m_dst_q;
    w_dst_d   = w_dst_q;
    e_vld_d   = e_vld_q;
    m_vld_d   = m_vld_q;
    w_vld_d   = w_vld_q;
    e_csq_d   = e_csq_q;
    m_csq_d   = m_csq_q;
    w_csq_d   = w_csq_q;
    bub_cnt_d = bub_cnt_q;

    case (cycle_act)
      ACT_ADVANCE: begin
        w_dst_d   = m_dst_q;
        w_vld_d   = m_vld_q;
        w_csq_d   = m_csq_q;
        m_dst_d   = e_dst_q;
        m_vld_d   = e_vld_q;
        m_csq_d   = e_csq_q;
        // Tag and qualifiers are captured even when VALID is 0; consumers gate on VALID.
        e_dst_d   = pipe_if.D_DST_I;
        e_vld_d   = pipe_if.D_VALID_I;
        e_csq_d   = pipe_if.D_CSQ_I;
        bub_cnt_d = {CNT_W{1'b0}};
      end
      ACT_BUBBLE: begin
        w_dst_d   = m_dst_q;
        w_vld_d   = m_vld_q;
        w_csq_d   = m_csq_q;
        m_dst_d   = e_dst_q;
        m_vld_d   = e_vld_q;
        m_csq_d   = e_csq_q;
        e_dst_d   = {TAG_W{1'b0}};
        e_vld_d   = 1'b0;
        e_csq_d   = {CSQ_W{1'b0}};
        if (bub_cnt_q == CNT_SAT) begin
          bub_cnt_d = CNT_SAT;
        end else begin
          bub_cnt_d = bub_cnt_q + CNT_W'(1);
        end
      end
      ACT_FLUSH: begin
        // Older instructions in E and M are kept; only the E slot is killed.
        w_dst_d   = m_dst_q;
        w_vld_d   = m_vld_q;
        w_csq_d   = m_csq_q;
        m_dst_d   = e_dst_q;
        m_vld_d   = e_vld_q;
        m_csq_d   = e_csq_q;
        e_dst_d   = {TAG_W{1'b0}};
        e_vld_d   = 1'b0;
        e_csq_d   = {CSQ_W{1'b0}};
        bub_cnt_d = {CNT_W{1'b0}};
      end
      ACT_HOLD: begin
        // Full freeze; a bubble streak resumes where it left off.
        bub_cnt_d = bub_cnt_q;
      end
      default: begin
        bub_cnt_d = bub_cnt_q;
      end
    endcase
  end

  // Timeout is sticky; it sets on the edge where the streak reaches MAX_BUBBLE+1.
  always_comb begin
    if (bub_cnt_d == CNT_SAT) begin
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_q;
    end
  end

  // Stage, counter and timeout registers.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      e_dst_q   <= {TAG_W{1'b0}};
      m_dst_q   <= {TAG_W{1'b0}};
      w_dst_q   <= {TAG_W{1'b0}};
      e_vld_q   <= 1'b0;
      m_vld_q   <= 1'b0;
      w_vld_q   <= 1'b0;
      e_csq_q   <= {CSQ_W{1'b0}};
      m_csq_q   <= {CSQ_W{1'b0}};
      w_csq_q   <= {CSQ_W{1'b0}};
      bub_cnt_q <= {CNT_W{1'b0}};
      timeout_q <= 1'b0;
    end else begin
      e_dst_q   <= e_dst_d;
      m_dst_q   <= m_dst_d;
      w_dst_q   <= w_dst_d;
      e_vld_q   <= e_vld_d;
      m_vld_q   <= m_vld_d;
      w_vld_q   <= w_vld_d;
      e_csq_q   <= e_csq_d;
      m_csq_q   <= m_csq_d;
      w_csq_q   <= w_csq_d;
      bub_cnt_q <= bub_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign pipe_if.E_DST_O          = e_dst_q;
  assign pipe_if.M_DST_O          = m_dst_q;
  assign pipe_if.W_DST_O          = w_dst_q;
  assign pipe_if.E_VALID_O        = e_vld_q;
  assign pipe_if.M_VALID_O        = m_vld_q;
  assign pipe_if.W_VALID_O        = w_vld_q;
  assign pipe_if.E_CSQ_O          = e_csq_q;
  assign pipe_if.M_CSQ_O          = m_csq_q;
  assign pipe_if.W_CSQ_O          = w_csq_q;
  assign pipe_if.HAZARD_TIMEOUT_O = timeout_q;

`ifdef CPU_DST_PIPE_STAT_EN
  logic [15:0] stat_bub_q;
  logic [15:0] stat_flush_q;

  // Saturating counters of bubble and flush cycles that actually took effect.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      stat_bub_q   <= 16'h0000;
      stat_flush_q <= 16'h0000;
    end else begin
      if ((cycle_act == ACT_BUBBLE) && (stat_bub_q != 16'hFFFF)) begin
        stat_bub_q <= stat_bub_q + 16'h0001;
      end else begin
        stat_bub_q <= stat_bub_q;
      end
      if ((cycle_act == ACT_FLUSH) && (stat_flush_q != 16'hFFFF)) begin
        stat_flush_q <= stat_flush_q + 16'h0001;
      end else begin
        stat_flush_q <= stat_flush_q;
      end
    end
  end

  assign STAT_BUBBLE_CNT_O = stat_bub_q;
  assign STAT_FLUSH_CNT_O  = stat_flush_q;
`endif

endmodule

// File: tb/tb_cpu_dst_pipe.sv
// Directed testbench for cpu_dst_pipe.
// Inputs change between edges; outputs are sampled 1 time unit after each rising edge.
module tb_cpu_dst_pipe;

  logic CLK_I = 1'b0;
  logic RST_I;
  int   checks = 0;
  int   errors = 0;

  cpu_dst_pipe_if #(.TAG_W(3), .CSQ_W(5)) bus ();

`ifdef CPU_DST_PIPE_STAT_EN
  logic [15:0] stat_bub;
  logic [15:0] stat_flush;
`endif

  cpu_dst_pipe #(.TAG_W(3), .CSQ_W(5), .MAX_BUBBLE(3)) dut (
    .CLK_I   (CLK_I),
    .RST_I   (RST_I),
    .pipe_if (bus)
`ifdef CPU_DST_PIPE_STAT_EN
    ,
    .STAT_BUBBLE_CNT_O (stat_bub),
    .STAT_FLUSH_CNT_O  (stat_flush)
`endif
  );

  always #5 CLK_I = ~CLK_I;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic drive(input logic [2:0] dst, input logic vld, input logic [4:0] csq,
                       input logic bub, input logic fl, input logic wt);
    bus.D_DST_I       = dst;
    bus.D_VALID_I     = vld;
    bus.D_CSQ_I       = csq;
    bus.BUBBLE_DATA_I = bub;
    bus.FLUSH_I       = fl;
    bus.MEM_WAIT_I    = wt;
    #1;
  endtask

  task automatic chk_stage(input string tag, input logic [2:0] ed, input logic ev,
                           input logic [2:0] md, input logic mv,
                           input logic [2:0] wd, input logic wv);
    chk({tag, "_edst"}, 32'(bus.E_DST_O), 32'(ed));
    chk({tag, "_evld"}, 32'(bus.E_VALID_O), 32'(ev));
    chk({tag, "_mdst"}, 32'(bus.M_DST_O), 32'(md));
    chk({tag, "_mvld"}, 32'(bus.M_VALID_O), 32'(mv));
    chk({tag, "_wdst"}, 32'(bus.W_DST_O), 32'(wd));
    chk({tag, "_wvld"}, 32'(bus.W_VALID_O), 32'(wv));
  endtask

  initial begin
    // Reset state
    RST_I = 1'b1;
    drive(3'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk_stage("rst", 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    chk("rst_ecsq", 32'(bus.E_CSQ_O), 32'd0);
    chk("rst_wcsq", 32'(bus.W_CSQ_O), 32'd0);
    chk("rst_tmo", 32'(bus.HAZARD_TIMEOUT_O), 32'd0);
    @(negedge CLK_I);
    RST_I = 1'b0;

    // Advance: tag 5 walks E -> M -> W
    drive(3'd5, 1'b1, 5'b00001, 1'b0, 1'b0, 1'b0);
    chk("adv_acc0", 32'(bus.D_ACCEPT_O), 32'd1);
    tick();
    chk_stage("adv1", 3'd5, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    chk("adv1_ecsq", 32'(bus.E_CSQ_O), 32'h01);
    chk("adv_acc1", 32'(bus.D_ACCEPT_O), 32'd1);
    tick();
    chk_stage("adv2", 3'd5, 1'b1, 3'd5, 1'b1, 3'd0, 1'b0);
    tick();
    chk_stage("adv3", 3'd5, 1'b1, 3'd5, 1'b1, 3'd5, 1'b1);
    chk("adv3_wcsq", 32'(bus.W_CSQ_O), 32'h01);

    // Bubble: E holds tag 2, decode holds tag 6 while bubble is high for two edges
    drive(3'd2, 1'b1, 5'b10010, 1'b0, 1'b0, 1'b0);
    tick();
    chk_stage("bub0", 3'd2, 1'b1, 3'd5, 1'b1, 3'd5, 1'b1);
    drive(3'd6, 1'b1, 5'b01100, 1'b1, 1'b0, 1'b0);
    chk("bub_acc", 32'(bus.D_ACCEPT_O), 32'd0);
    tick();
    chk_stage("bub1", 3'd0, 1'b0, 3'd2, 1'b1, 3'd5, 1'b1);
    chk("bub1_ecsq", 32'(bus.E_CSQ_O), 32'h00);
    chk("bub1_mcsq", 32'(bus.M_CSQ_O), 32'h12);
    tick();
    chk_stage("bub2", 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1);
    drive(3'd6, 1'b1, 5'b01100, 1'b0, 1'b0, 1'b0);
    chk("bub_rel_acc", 32'(bus.D_ACCEPT_O), 32'd1);
    tick();
    chk_stage("bub3", 3'd6, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    chk("bub3_ecsq", 32'(bus.E_CSQ_O), 32'h0C);
    chk("bub3_tmo", 32'(bus.HAZARD_TIMEOUT_O), 32'd0);

    // Wait has priority over flush and bubble
    drive(3'd3, 1'b1, 5'b00011, 1'b0, 1'b0, 1'b0);
    tick();
    chk_stage("pre_wt", 3'd3, 1'b1, 3'd6, 1'b1, 3'd0, 1'b0);
    drive(3'd1, 1'b1, 5'b00001, 1'b1, 1'b1, 1'b1);
    chk("wt_acc", 32'(bus.D_ACCEPT_O), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_stage("wt", 3'd3, 1'b1, 3'd6, 1'b1, 3'd0, 1'b0);
      chk("wt_ecsq", 32'(bus.E_CSQ_O), 32'h03);
    end
    // Release: flush wins over the still-asserted bubble
    drive(3'd1, 1'b1, 5'b00001, 1'b1, 1'b1, 1'b0);
    chk("fl_acc", 32'(bus.D_ACCEPT_O), 32'd0);
    tick();
    chk_stage("fl", 3'd0, 1'b0, 3'd3, 1'b1, 3'd6, 1'b1);
    chk("fl_ecsq", 32'(bus.E_CSQ_O), 32'h00);

    // Timeout, with a wait in the middle of the streak freezing the counter
    drive(3'd1, 1'b1, 5'b00001, 1'b0, 1'b0, 1'b0);
    tick();
    drive(3'd4, 1'b1, 5'b00001, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    chk("tmo_b2", 32'(bus.HAZARD_TIMEOUT_O), 32'd0);
    drive(3'd4, 1'b1, 5'b00001, 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    chk("tmo_wt", 32'(bus.HAZARD_TIMEOUT_O), 32'd0);
    drive(3'd4, 1'b1, 5'b00001, 1'b1, 1'b0, 1'b0);
    tick();
    chk("tmo_b3", 32'(bus.HAZARD_TIMEOUT_O), 32'd0);
    tick();
    chk("tmo_b4", 32'(bus.HAZARD_TIMEOUT_O), 32'd1);
    drive(3'd4, 1'b1, 5'b00001, 1'b0, 1'b0, 1'b0);
    tick();
    chk("tmo_sticky", 32'(bus.HAZARD_TIMEOUT_O), 32'd1);
    chk("tmo_edst", 32'(bus.E_DST_O), 32'd4);

    // Asynchronous reset mid-cycle with every stage valid
    drive(3'd7, 1'b1, 5'b11111, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk_stage("full", 3'd7, 1'b1, 3'd7, 1'b1, 3'd7, 1'b1);
    #2;
    RST_I = 1'b1;
    #1;
    chk_stage("arst", 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    chk("arst_mcsq", 32'(bus.M_CSQ_O), 32'h00);
    chk("arst_tmo", 32'(bus.HAZARD_TIMEOUT_O), 32'd0);
    @(negedge CLK_I);
    RST_I = 1'b0;

    // Advance with D_VALID_I = 0: VALID low, tag and qualifiers still captured
    drive(3'd4, 1'b0, 5'b00101, 1'b0, 1'b0, 1'b0);
    tick();
    chk("nv_evld", 32'(bus.E_VALID_O), 32'd0);
    chk("nv_edst", 32'(bus.E_DST_O), 32'd4);
    chk("nv_ecsq", 32'(bus.E_CSQ_O), 32'h05);

`ifdef CPU_DST_PIPE_STAT_EN
    // Statistics: 5 bubble requests, one overridden by a flush; 2 flushes
    @(negedge CLK_I);
    RST_I = 1'b1;
    #1;
    chk("st_rst_b", 32'(stat_bub), 32'd0);
    chk("st_rst_f", 32'(stat_flush), 32'd0);
    @(negedge CLK_I);
    RST_I = 1'b0;
    drive(3'd1, 1'b1, 5'b00001, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    drive(3'd1, 1'b1, 5'b00001, 1'b1, 1'b1, 1'b0);
    tick();
    drive(3'd1, 1'b1, 5'b00001, 1'b0, 1'b1, 1'b0);
    tick();
    drive(3'd1, 1'b1, 5'b00001, 1'b0, 1'b0, 1'b0);
    tick();
    chk("st_bub", 32'(stat_bub), 32'd4);
    chk("st_flush", 32'(stat_flush), 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
